// File: rtl/wb_spi_master_if.sv
// Wishbone classic slave bundle for the SPI master. The slave modport is the
// DUT view; the master modport is the view of the interconnect or bench.
interface wb_spi_master_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [1:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_spi_master.sv
// Wishbone-controlled SPI master: mode 0, MSB first, 8-bit frames, with
// CTRL/STATUS/TXDATA/RXDATA registers and a level interrupt on completion.
module wb_spi_master #(
  parameter logic [7:0] DIV_RST = 8'd3
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_spi_master_if.slave  wb,
  output logic            spi_sclk,
  output logic            spi_mosi,
  output logic            spi_cs_n,
  input  logic            spi_miso,
  output logic            irq
);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

  state_t      r_state;
  logic [7:0]  r_clk_div;
  logic [7:0]  r_div_lat;
  logic [7:0]  r_cnt;
  logic [7:0]  r_tx;
  logic [7:0]  r_rx_sh;
  logic [7:0]  r_rxdata;
  logic [2:0]  r_bit;
  logic        r_irq_en;
  logic        r_done;
  logic        r_ovr;
  logic        r_ack;
  logic        r_sclk;
  logic        r_mosi;
  logic        r_cs_n;
  logic [31:0] r_dat;

  logic        w_acc;
  logic        w_wr;
  logic        w_busy;
  logic        w_cnt_end;
  logic        w_txd_wr;
  logic [31:0] w_rdat;
  logic        w_unused;

  assign w_acc     = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
  assign w_wr      = w_acc & wb.wb_we_i & (|wb.wb_sel_i);
  assign w_busy    = (r_state != S_IDLE);
  assign w_cnt_end = (r_cnt == r_div_lat);
  assign w_txd_wr  = w_wr && (wb.wb_adr_i == 2'd2);
  assign w_unused  = ^wb.wb_dat_i[31:9];

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_dat_o = r_dat;
  assign spi_sclk    = r_sclk;
  assign spi_mosi    = r_mosi;
  assign spi_cs_n    = r_cs_n;
  assign irq         = r_done & r_irq_en;

  always_comb begin
    w_rdat = '0;
    case (wb.wb_adr_i)
      2'd0:    w_rdat = {23'd0, r_irq_en, r_clk_div};
      2'd1:    w_rdat = {29'd0, r_ovr, r_done, w_busy};
      2'd3:    w_rdat = {24'd0, r_rxdata};
      default: w_rdat = '0;
    endcase
  end

  // Bus stage: single-cycle ack, read data presented only alongside ack
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_clk_div <= DIV_RST;
      r_irq_en  <= 1'b0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc && !wb.wb_we_i) ? w_rdat : '0;
      if (w_wr && (wb.wb_adr_i == 2'd0)) begin
        r_clk_div <= wb.wb_dat_i[7:0];
        r_irq_en  <= wb.wb_dat_i[8];
      end
    end
  end

  // Transfer FSM: every phase lasts r_div_lat+1 cycles; done-set is written
  // after the W1C clear so a completion in the same cycle wins.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= S_IDLE;
      r_sclk   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_mosi   <= 1'b0;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
      r_rxdata <= '0;
      r_cnt    <= '0;
      r_bit    <= '0;
    end else begin
      if (w_wr && (wb.wb_adr_i == 2'd1)) begin
        if (wb.wb_dat_i[1]) r_done <= 1'b0;
        if (wb.wb_dat_i[2]) r_ovr  <= 1'b0;
      end
      if (w_txd_wr && w_busy) r_ovr <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_txd_wr) begin
            r_state   <= S_LEAD;
            r_cs_n    <= 1'b0;
            r_mosi    <= wb.wb_dat_i[7];
            r_tx      <= wb.wb_dat_i[7:0];
            r_div_lat <= r_clk_div;
            r_cnt     <= '0;
            r_bit     <= '0;
          end
        end
        S_LEAD: begin
          if (w_cnt_end) begin
            r_cnt   <= '0;
            r_state <= S_XFER;
            r_sclk  <= 1'b1;
            r_rx_sh <= {r_rx_sh[6:0], spi_miso};
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_XFER: begin
          if (w_cnt_end) begin
            r_cnt <= '0;
            if (r_sclk) begin
              r_sclk <= 1'b0;
              if (r_bit != 3'd7) begin
                r_tx   <= {r_tx[6:0], 1'b0};
                r_mosi <= r_tx[6];
              end
            end else if (r_bit == 3'd7) begin
              r_state <= S_TRAIL;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_sclk  <= 1'b1;
              r_rx_sh <= {r_rx_sh[6:0], spi_miso};
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_TRAIL: begin
          if (w_cnt_end) begin
            r_state  <= S_IDLE;
            r_cs_n   <= 1'b1;
            r_done   <= 1'b1;
            r_rxdata <= r_rx_sh;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_spi_master.md
WB_SPI_MASTER -- requirements
Module: wb_spi_master

Interface
REQ-001 The block SHALL be a Wishbone slave occupying interconnect slave slot 2 and SHALL drive an SPI master (mode 0, MSB first, 8-bit frames).
REQ-002 Parameter DIV_RST, default 8'd3, SHALL set the reset value of CTRL.clk_div.
REQ-003 wb_clk_i  in  1  SHALL be the single clock; all state SHALL change only on its rising edge.
REQ-004 wb_rst_i  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  SHALL be the Wishbone cycle, strobe and write-enable.
REQ-006 wb_adr_i  in  2  SHALL be the word register index.
REQ-007 wb_dat_i  in  32  SHALL be write data; wb_sel_i  in  4  SHALL be the byte enables.
REQ-008 wb_dat_o  out  32  SHALL be read data; wb_ack_o  out  1  SHALL be the acknowledge.
REQ-009 spi_sclk  out  1, spi_mosi  out  1, spi_cs_n  out  1, spi_miso  in  1  SHALL be the SPI pins.
REQ-010 irq  out  1  SHALL be the level interrupt.

Function
REQ-011 Register map: 0 CTRL (rw: [7:0] clk_div, [8] irq_en); 1 STATUS ([0] busy ro, [1] done W1C, [2] overrun W1C); 2 TXDATA (wo, [7:0]); 3 RXDATA (ro, [7:0]); unused bits SHALL read 0.
REQ-012 Bus access SHALL be accepted in a cycle where cyc&stb&!ack; wb_ack_o SHALL be high for exactly the next cycle and low in the cycle after that, so back-to-back requests each take 2 cycles.
REQ-013 wb_dat_o SHALL be valid while wb_ack_o=1 and SHALL be 0 otherwise; reads SHALL have no side effects.
REQ-014 A write with wb_sel_i=4'b0000 SHALL be acked and SHALL have no effect; any other wb_sel_i SHALL write all fields of the addressed register.
REQ-015 A TXDATA write while busy=0 SHALL start a transfer: in the cycle after acceptance busy=1, spi_cs_n=0, spi_mosi=bit7, FSM=LEAD.
REQ-016 A TXDATA write while busy=1 SHALL be acked, SHALL be discarded, and SHALL set overrun; the transfer in progress SHALL be unaffected.
REQ-017 A CTRL write while busy=1 SHALL update the register, but the running transfer SHALL use the clk_div latched at start.
REQ-018 Let H = clk_div+1 cycles; FSM states SHALL be IDLE -> LEAD (H cycles) -> XFER (8 bits, each H cycles sclk=1 then H cycles sclk=0) -> TRAIL (H cycles) -> IDLE.
REQ-019 On each sclk 0->1 transition the block SHALL shift spi_miso, as sampled in that cycle, into the receive shift register LSB.
REQ-020 On each sclk 1->0 transition except the 8th, spi_mosi SHALL advance to the next lower bit; after the 8th, spi_mosi SHALL hold bit0 until IDLE.
REQ-021 busy SHALL remain 1 for exactly 18*H cycles.
REQ-022 On leaving TRAIL, in the same cycle: spi_cs_n=1, busy=0, done=1, RXDATA=received byte.
REQ-023 A STATUS write SHALL clear done and overrun where the wb_dat_i bit is 1; if done-set and W1C occur in the same cycle, set SHALL win.
REQ-024 irq SHALL equal done & irq_en, registered-free (combinational from flops).
REQ-025 In IDLE, spi_sclk=0 and spi_cs_n=1; spi_mosi SHALL hold its last value.

Reset
REQ-026 wb_rst_i=1 at a clock edge SHALL force in that edge: FSM=IDLE, spi_sclk=0, spi_cs_n=1, spi_mosi=0, wb_ack_o=0, wb_dat_o=0, irq=0, clk_div=DIV_RST, irq_en=0, busy=done=overrun=0, RXDATA=0.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer without setting done, and any pending ack SHALL be dropped.

Verification
REQ-028 Reset then read all four registers -> CTRL=0x00000003, STATUS=0, TXDATA reads 0, RXDATA=0; spi_cs_n=1, spi_sclk=0.
REQ-029 clk_div=0, miso looped to mosi, write TXDATA=0xA5 -> busy exactly 18 cycles, 8 sclk pulses each 1 cycle high, mosi bits 1,0,1,0,0,1,0,1, RXDATA=0xA5, done=1.
REQ-030 clk_div=3, miso tied 1, write TXDATA=0x00 -> sclk high 4 cycles per bit, busy 72 cycles, RXDATA=0xFF.
REQ-031 Write TXDATA=0x3C during transfer of 0x5A -> ack received, overrun=1, transmitted byte remains 0x5A, busy length unchanged.
REQ-032 irq_en=1, complete a transfer -> irq=1; write STATUS=0x2 -> done=0, irq=0 in the cycle after ack.
REQ-033 Assert wb_rst_i for 1 cycle at bit 4 of a transfer -> next cycle spi_cs_n=1, spi_sclk=0, busy=0, done=0, RXDATA=0.
